instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the Simple RISC Machine: owns the program counter, issues reads
//  to instruction memory, and delivers each 16-bit word plus a one-cycle load
//  strobe into the instruction register. Sits between instruction memory and the
//  instruction register. The main controller starts each fetch and may redirect the PC.
// PARAMETERS
//  ADDR_W    9   PC / memory address width; word-addressed
//  DATA_W    16  instruction width
//  RESET_PC  0   PC value loaded on reset
//  MEM_LAT   1   memory read latency in cycles, >=1; mem_rdata valid MEM_LAT cycles after mem_rd
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       request next fetch; sampled only in IDLE
//  pc_load     in   1       redirect PC to pc_target (branch)
//  pc_target   in   ADDR_W  redirect address
//  mem_rd      out  1       memory read strobe, one cycle
//  mem_addr    out  ADDR_W  read address; equals pc when not redirecting
//  mem_rdata   in   DATA_W  memory read data
//  ir_load     out  1       one-cycle pulse; drives instruction-register load
//  ir_out      out  DATA_W  fetched word; drives instruction-register data in
//  pc          out  ADDR_W  current PC
//  busy        out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, ir_out=0, mem_rd=0, ir_load=0, busy=0.
//  FSM states: IDLE -> REQ -> WAIT -> CAP -> IDLE.
//  IDLE: start=1 -> REQ. pc_load=1 -> pc<=pc_target. Both together: redirect wins;
//   REQ fetches from pc_target.
//  REQ: mem_rd=1, mem_addr=pc, wait counter <= MEM_LAT-1; -> CAP if MEM_LAT==1, else -> WAIT.
//  WAIT: counter decrements; -> CAP when counter reaches 1.
//  CAP: ir_out<=mem_rdata, ir_load=1 for exactly this cycle, pc<=pc+1 mod 2**ADDR_W
//   (pc = 2**ADDR_W-1 wraps to 0); -> IDLE.
//  Fetch latency: start to ir_load = MEM_LAT+1 cycles (2 cycles at default).
//  pc_load while busy: latch target into a pending redirect. At CAP, pc<=pending
//   target instead of pc+1. The in-flight word is still delivered. A later pc_load
//   overwrites an earlier pending one.
//  start while busy: ignored, not queued.
//  ir_out holds its value between fetches. mem_rd and ir_load are never high in
//   the same cycle.
//  Async reset mid-fetch: abort immediately. Drop the pending redirect. No ir_load.
// CONFIGURATION
//  FETCH_HALT_EN defined: at CAP, if ir_out[15:13]==HALT_OPCODE, go to HALTED
//   (pc not advanced, busy=1) and add output halted=1. Only reset leaves HALTED;
//   start and pc_load are ignored there.
//  FETCH_HALT_EN undefined: no HALTED state and no halted port. The HALT opcode is
//   fetched like any other word.
// STRUCTURE
//  fetch_pkg: typedef enum logic [2:0] fetch_state_t {IDLE,REQ,WAIT,CAP,HALTED};
//   localparam HALT_OPCODE = 3'b111.
//  Sub-module pc_counter (load/increment/wrap PC register with async reset);
//   everything else stays in instr_fetch.
// TESTING
//  1 reset, start pulse, MEM_LAT=1, mem[0]=16'hD105 -> mem_rd@cyc1 addr 0;
//    ir_load@cyc2 with ir_out=D105; pc=1; busy low at cyc3.
//  2 pc_load=1, pc_target=9'h1F0 with start in IDLE -> mem_addr=1F0;
//    after CAP pc=1F1.
//  3 pc=9'h1FF, fetch -> pc wraps to 0. MEM_LAT=3 -> ir_load exactly 4 cycles
//    after start.
//  4 pc_load target 9'h020 during WAIT -> in-flight word delivered, pc=020 after CAP;
//    start during busy -> no extra mem_rd.
//  5 rst_n low during WAIT -> all outputs at reset values immediately; no ir_load;
//    next fetch reads RESET_PC.
//  6 FETCH_HALT_EN, mem word 16'hE000 -> halted=1, pc frozen, start ignored;
//    without the macro -> normal fetch, pc increments.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage of the Simple RISC Machine.
// Optional halt support is enabled with FETCH_HALT_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAP,
    HALTED
  } fetch_state_t;

  localparam logic [2:0] HALT_OPCODE = 3'b111;

  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load, increment with wrap, async reset.
// Load has priority over increment.
module pc_counter
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, pulses IR load.
// Define FETCH_HALT_EN to stop in HALTED on a HALT opcode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_load,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
`ifdef FETCH_HALT_EN
  ,
  output logic              halted
`endif
);

  localparam int CW = cnt_w(MEM_LAT);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_tgt;
  logic [DATA_W-1:0] ir_q;
  logic              pc_ld;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_val;
  logic              halt_hit;

`ifdef FETCH_HALT_EN
  assign halt_hit = (mem_rdata[DATA_W-1 -: 3] == HALT_OPCODE);
  assign halted   = (state == HALTED);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mem_rd   = 1'b0;
    ir_load  = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_val   = pc_target;
    unique case (state)
      IDLE: begin
        pc_ld = pc_load;
        if (start) state_nx = REQ;
      end
      REQ: begin
        mem_rd   = 1'b1;
        cnt_nx   = CW'(MEM_LAT - 1);
        state_nx = (MEM_LAT == 1) ? CAP : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = CAP;
      end
      CAP: begin
        ir_load  = 1'b1;
        state_nx = IDLE;
        if (halt_hit) begin
          state_nx = HALTED;
        end else if (pc_load || pend_vld) begin
          pc_ld  = 1'b1;
          pc_val = pc_load ? pc_target : pend_tgt;
        end else begin
          pc_inc = 1'b1;
        end
      end
      HALTED: state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  // Redirects arriving mid-fetch are parked until the word is delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_tgt <= '0;
    end else if (state == CAP) begin
      pend_vld <= 1'b0;
    end else if (pc_load && (state == REQ || state == WAIT)) begin
      pend_vld <= 1'b1;
      pend_tgt <= pc_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= mem_rdata;
    end
  end

  // Bypass so the IR sees valid data in the same cycle as ir_load
  assign ir_out   = ir_load ? mem_rdata : ir_q;
  assign mem_addr = pc;
  assign busy     = (state != IDLE);

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_ld),
    .inc     (pc_inc),
    .load_val(pc_val),
    .pc      (pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (MEM_LAT 1 and 3) against a
// transaction-level fetch model and a delayed-read memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s   [2];
  logic        pc_load_s [2];
  logic [8:0]  tgt_s     [2];
  logic        mem_rd_s  [2];
  logic [8:0]  addr_s    [2];
  logic [15:0] rdata_s   [2];
  logic        ir_load_s [2];
  logic [15:0] ir_s      [2];
  logic [8:0]  pc_s      [2];
  logic        busy_s    [2];
`ifdef FETCH_HALT_EN
  logic        halted_s  [2];
`endif

  logic [15:0] mem [512];
  logic [15:0] dl1;
  logic [15:0] dl3 [3];
  logic [8:0]  pc_m [2];
  logic [15:0] ir_m [2];
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl1    <= mem_rd_s[0] ? mem[addr_s[0]] : 16'hDEAD;
    dl3[0] <= mem_rd_s[1] ? mem[addr_s[1]] : 16'hDEAD;
    dl3[1] <= dl3[0];
    dl3[2] <= dl3[1];
  end
  assign rdata_s[0] = dl1;
  assign rdata_s[1] = dl3[2];

  instr_fetch #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .start(start_s[0]), .pc_load(pc_load_s[0]),
    .pc_target(tgt_s[0]), .mem_rd(mem_rd_s[0]),
    .mem_addr(addr_s[0]), .mem_rdata(rdata_s[0]),
    .ir_load(ir_load_s[0]), .ir_out(ir_s[0]),
    .pc(pc_s[0]), .busy(busy_s[0])
`ifdef FETCH_HALT_EN
    , .halted(halted_s[0])
`endif
  );

  instr_fetch #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .start(start_s[1]), .pc_load(pc_load_s[1]),
    .pc_target(tgt_s[1]), .mem_rd(mem_rd_s[1]),
    .mem_addr(addr_s[1]), .mem_rdata(rdata_s[1]),
    .ir_load(ir_load_s[1]), .ir_out(ir_s[1]),
    .pc(pc_s[1]), .busy(busy_s[1])
`ifdef FETCH_HALT_EN
    , .halted(halted_s[1])
`endif
  );

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({pc_s[d], ir_s[d], mem_rd_s[d], ir_load_s[d], busy_s[d]}
          !== {9'h0, 16'h0, 3'b000}) begin
        nerr++;
        $display("FAIL %s d%0d: pc=%h ir=%h rd=%b ld=%b busy=%b want all 0",
                 tag, d, pc_s[d], ir_s[d], mem_rd_s[d], ir_load_s[d], busy_s[d]);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; pc_load_s[d] = 1'b0; tgt_s[d] = '0;
      pc_m[d] = '0; ir_m[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete fetch; mask bit c issues pc_load in busy cycle c
  task automatic fetch(input int d, input bit idle_redir, input logic [8:0] tgt,
                       input int unsigned mask, input bit busy_start);
    int lat, last, rd_cnt, ld_cyc;
    logic [8:0]  addr, exp_pc;
    logic [15:0] word;
    lat  = (d == 0) ? 1 : 3;
    last = 0;
    for (int c = 1; c <= lat + 1; c++) if (mask[c]) last = c;
    nvec++;
    if (ir_s[d] !== ir_m[d]) begin
      nerr++;
      $display("FAIL ir_hold d%0d: got %h want %h", d, ir_s[d], ir_m[d]);
    end
    if (idle_redir) pc_m[d] = tgt;
    addr   = pc_m[d];
    word   = mem[addr];
    exp_pc = (last != 0) ? tgt : addr + 9'd1;
    start_s[d] = 1'b1; pc_load_s[d] = idle_redir; tgt_s[d] = tgt;
    @(negedge clk);
    start_s[d] = 1'b0; pc_load_s[d] = 1'b0;
    rd_cnt = 0; ld_cyc = 0;
    for (int c = 1; c <= lat + 1; c++) begin
      nvec++;
      if (busy_s[d] !== 1'b1 || (mem_rd_s[d] && ir_load_s[d])) begin
        nerr++;
        $display("FAIL busy_cyc d%0d c%0d: busy=%b rd=%b ld=%b want busy=1 no overlap",
                 d, c, busy_s[d], mem_rd_s[d], ir_load_s[d]);
      end
      if (mem_rd_s[d]) begin
        rd_cnt++;
        nvec++;
        if (addr_s[d] !== addr) begin
          nerr++;
          $display("FAIL mem_addr d%0d: got %h want %h", d, addr_s[d], addr);
        end
      end
      if (ir_load_s[d]) begin
        ld_cyc = c;
        nvec++;
        if (ir_s[d] !== word) begin
          nerr++;
          $display("FAIL ir_word d%0d: got %h want %h", d, ir_s[d], word);
        end
      end
      if (mask[c]) begin
        pc_load_s[d] = 1'b1;
        tgt_s[d] = (c == last) ? tgt : 9'($urandom);
      end
      start_s[d] = busy_start;
      @(negedge clk);
      pc_load_s[d] = 1'b0; start_s[d] = 1'b0;
    end
    nvec++;
    if (rd_cnt != 1 || ld_cyc != lat + 1) begin
      nerr++;
      $display("FAIL timing d%0d: rd_cnt=%0d ld_cyc=%0d want 1 and %0d",
               d, rd_cnt, ld_cyc, lat + 1);
    end
    nvec++;
    if (pc_s[d] !== exp_pc || ir_s[d] !== word || busy_s[d] !== 1'b0) begin
      nerr++;
      $display("FAIL post d%0d: pc=%h ir=%h busy=%b want pc=%h ir=%h busy=0",
               d, pc_s[d], ir_s[d], busy_s[d], exp_pc, word);
    end
    pc_m[d] = exp_pc;
    ir_m[d] = word;
    @(negedge clk);
    nvec++;
    if (busy_s[d] !== 1'b0 || mem_rd_s[d] !== 1'b0) begin
      nerr++;
      $display("FAIL no_queue d%0d: busy=%b rd=%b want 0 0", d, busy_s[d], mem_rd_s[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; pc_load_s[d] = 1'b0; tgt_s[d] = '0;
      pc_m[d] = '0; ir_m[d] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
  endtask

  task automatic test_basic();
    mem[0] = 16'hD105;
    fetch(0, 1'b0, 9'h0, 0, 1'b0);
  endtask

  task automatic test_redirect_idle();
    fetch(0, 1'b1, 9'h1F0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    fetch(1, 1'b1, 9'h1FF, 0, 1'b0);
    fetch(0, 1'b1, 9'h1FF, 0, 1'b0);
  endtask

  task automatic test_busy_redirect();
    fetch(1, 1'b0, 9'h020, 32'h4, 1'b1);
    fetch(0, 1'b0, 9'h155, 32'h6, 1'b1);
    fetch(1, 1'b0, 9'h0A3, 32'h1E, 1'b0);
  endtask

  task automatic test_random();
    int d, lat;
    int unsigned mask;
    for (int i = 0; i < 40; i++) begin
      d    = int'($urandom_range(0, 1));
      lat  = (d == 0) ? 1 : 3;
      mask = $urandom & ((32'd1 << (lat + 2)) - 32'd2);
      if ($urandom_range(0, 2) == 0) mask = 0;
      fetch(d, 1'($urandom_range(0, 3) == 0), 9'($urandom), mask,
            1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    pc_load_s[1] = 1'b1; tgt_s[1] = 9'h0AA;
    @(negedge clk);
    pc_load_s[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    for (int d = 0; d < 2; d++) begin
      pc_m[d] = '0; ir_m[d] = '0;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nvec++;
      if (ir_load_s[0] !== 1'b0 || ir_load_s[1] !== 1'b0) begin
        nerr++;
        $display("FAIL reset_no_load c%0d: ld=%b%b want 00", c, ir_load_s[0], ir_load_s[1]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    fetch(1, 1'b0, 9'h0, 0, 1'b0);
  endtask

  task automatic test_halt();
    logic [8:0] old_pc;
    old_pc = pc_m[0];
    mem[old_pc] = 16'hE000;
`ifdef FETCH_HALT_EN
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    nvec++;
    if (ir_load_s[0] !== 1'b1 || ir_s[0] !== 16'hE000) begin
      nerr++;
      $display("FAIL halt_load: ld=%b ir=%h want 1 e000", ir_load_s[0], ir_s[0]);
    end
    for (int c = 0; c < 4; c++) begin
      start_s[0] = 1'b1; pc_load_s[0] = 1'b1; tgt_s[0] = 9'h033;
      @(negedge clk);
      nvec++;
      if (halted_s[0] !== 1'b1 || busy_s[0] !== 1'b1 ||
          pc_s[0] !== old_pc || mem_rd_s[0] !== 1'b0) begin
        nerr++;
        $display("FAIL halted c%0d: halted=%b busy=%b pc=%h rd=%b want 1 1 %h 0",
                 c, halted_s[0], busy_s[0], pc_s[0], mem_rd_s[0], old_pc);
      end
    end
    apply_reset();
    nvec++;
    if (halted_s[0] !== 1'b0) begin
      nerr++;
      $display("FAIL halt_reset: halted=%b want 0", halted_s[0]);
    end
`else
    fetch(0, 1'b0, 9'h0, 0, 1'b0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:13] == 3'b111) mem[i][15] = 1'b0;
    end
    test_reset();
    test_basic();
    test_redirect_idle();
    test_wrap();
    test_busy_redirect();
    test_random();
    test_reset_mid();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
